// File: rtl/taylor_io_pkg.sv
// Shared constants and helpers for the Taylor-network input staging path.
package taylor_io_pkg;

    localparam int TAYLOR_NCH   = 4;
    localparam int TAYLOR_WIDTH = 19;
    localparam int TAYLOR_DEPTH = 8;

    // Occupancy needs one extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/taylor_ch_fifo.sv
// Single-channel circular FIFO with a hold register that remembers the last popped sample.
module taylor_ch_fifo
    import taylor_io_pkg::*;
#(
    parameter int WIDTH = TAYLOR_WIDTH,
    parameter int DEPTH = TAYLOR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         hold_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign hold_o  = hold_q;
    assign count_o = count_q;

    // Full/empty come from registered count only, so a same-cycle pop never admits a push.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/taylor_in_stage.sv
// Input staging for the Taylor-network processor: per-channel FIFOs served onto io_in by one-hot req_in.
module taylor_in_stage
    import taylor_io_pkg::*;
#(
    parameter int NCH   = TAYLOR_NCH,
    parameter int WIDTH = TAYLOR_WIDTH,
    parameter int DEPTH = TAYLOR_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH*WIDTH-1:0]          wr_data,
    input  logic [NCH-1:0]                wr_valid,
    output logic [NCH-1:0]                wr_ready,
    input  logic [NCH-1:0]                req_in,
    output logic [WIDTH-1:0]              io_in,
    output logic [NCH*lvl_w(DEPTH)-1:0]   level,
    output logic [NCH-1:0]                underflow,
    output logic                          err_multi,
    input  logic                          clr_err
);

    localparam int LW = lvl_w(DEPTH);

    logic [NCH-1:0][WIDTH-1:0] head;
    logic [NCH-1:0][WIDTH-1:0] hold;
    logic [NCH-1:0][LW-1:0]    count;
    logic [NCH-1:0]            full, empty;
    logic [NCH-1:0]            sel_oh;
    logic                      multi;
    logic [NCH-1:0]            underflow_q, underflow_d;
    logic                      err_multi_q, err_multi_d;

    // Lowest set request wins; any further set bit flags a malformed strobe.
    always_comb begin
        logic found;
        found  = 1'b0;
        sel_oh = '0;
        multi  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (req_in[k]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    sel_oh[k] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        taylor_ch_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (wr_valid[k]),
            .data_i  (wr_data[k*WIDTH +: WIDTH]),
            .pop_i   (sel_oh[k]),
            .head_o  (head[k]),
            .hold_o  (hold[k]),
            .count_o (count[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );
        assign level[k*LW +: LW] = count[k];
    end

    assign wr_ready = ~full;

    // An empty channel replays its last popped value rather than stale storage.
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_oh[k]) io_in = empty[k] ? hold[k] : head[k];
        end
    end

    assign underflow_d = (clr_err ? '0 : underflow_q) | (sel_oh & empty);
    assign err_multi_d = (err_multi_q & ~clr_err) | multi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= '0;
            err_multi_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign underflow = underflow_q;
    assign err_multi = err_multi_q;

endmodule
